// File: rtl/div_pkg.sv
// Shared types and constants for the unsigned restoring divider.
package div_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_datapath.sv
// Restoring-division datapath: 2*WIDTH working register, latched divisor, WIDTH+1-bit subtractor.
// One quotient bit per i_step; i_load takes priority over i_step.
module div_datapath
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_load_dz,
    input  logic               i_step,
    input  logic [WIDTH-1:0]   i_dividend,
    input  logic [WIDTH-1:0]   i_divisor,
    output logic [2*WIDTH-1:0] o_work
);

    logic [2*WIDTH-1:0] r_work;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH:0]     w_minuend;
    logic [WIDTH:0]     w_diff;
    logic               w_borrow;

    // Shifted upper half keeps the bit shifted out of the top, so divisors above
    // 2^(WIDTH-1) still compare correctly.
    assign w_minuend = r_work[2*WIDTH-1:WIDTH-1];
    assign w_diff    = w_minuend - {1'b0, r_divisor};
    assign w_borrow  = w_diff[WIDTH];
    assign o_work    = r_work;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_work    <= '0;
            r_divisor <= '0;
        end else if (i_load) begin
            // Divide-by-zero preloads the final answer: remainder = dividend, quotient = all ones.
            r_work    <= i_load_dz ? {i_dividend, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, i_dividend};
            r_divisor <= i_divisor;
        end else if (i_step) begin
            if (!w_borrow)
                r_work <= {w_diff[WIDTH-1:0], r_work[WIDTH-2:0], 1'b1};
            else
                r_work <= {w_minuend[WIDTH-1:0], r_work[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/unsigned_divider.sv
// Unsigned WIDTH-bit divider: IDLE/RUN/DONE FSM and step counter driving div_datapath.
// Result valid WIDTH edges after an accepted start (one edge for divide-by-zero); starts during RUN are ignored.
module unsigned_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    output logic             busy,
    output logic             rdy,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    div_state_t         r_state;
    div_state_t         w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_dz;
    logic               w_load;
    logic               w_load_dz;
    logic               w_step;
    logic [2*WIDTH-1:0] w_work;

    div_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_dz  (w_load_dz),
        .i_step     (w_step),
        .i_dividend (dividend_in),
        .i_divisor  (divisor_in),
        .o_work     (w_work)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dz    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_cnt <= '0;
                r_dz  <= w_load_dz;
            end else if (w_step) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_load_dz = 1'b0;
        w_step    = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_load = 1'b1;
                    if (divisor_in == '0) begin
                        w_load_dz = 1'b1;
                        w_next    = DONE;
                    end else begin
                        w_next = RUN;
                    end
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (r_cnt == CNT_W'(WIDTH - 1))
                    w_next = DONE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign busy        = (r_state == RUN);
    assign rdy         = (r_state == DONE);
    assign quotient    = rdy ? w_work[WIDTH-1:0] : '0;
    assign remainder   = rdy ? w_work[2*WIDTH-1:WIDTH] : '0;
    assign div_by_zero = rdy & r_dz;

endmodule

// File: tb/tb_unsigned_divider.sv
// Self-checking bench for unsigned_divider against a plain-arithmetic division model.
module tb_unsigned_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend_in = '0;
    logic [W-1:0] divisor_in = '0;
    logic         busy;
    logic         rdy;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    unsigned_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend_in (dividend_in),
        .divisor_in  (divisor_in),
        .busy        (busy),
        .rdy         (rdy),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Expected results from plain arithmetic.
    function automatic logic [W-1:0] model_q(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == 0) ? {W{1'b1}} : a / b;
    endfunction
    function automatic logic [W-1:0] model_r(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == 0) ? a : a % b;
    endfunction

    // Drive one start pulse at a negedge; returns at the negedge after the accepting edge.
    task automatic pulse_start(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1; dividend_in = a; divisor_in = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count edges until rdy, bounded; 999 marks an expired bound.
    task automatic wait_rdy(output int cycles);
        cycles = 0;
        while (!rdy && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        if (!rdy) cycles = 999;
    endtask

    task automatic test_reset;
        n_checks++;
        if ({busy, rdy, div_by_zero, quotient, remainder} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b rdy=%b dz=%b q=%h r=%h, need all 0",
                     busy, rdy, div_by_zero, quotient, remainder);
        end
        @(negedge clk); rst = 1'b0; @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b rdy=%b, need 0 0", busy, rdy);
        end
    endtask

    task automatic test_basic;
        int cyc;
        pulse_start(32'd100, 32'd7);
        n_checks++;
        if (busy !== 1'b1 || rdy !== 1'b0 || quotient !== '0 || remainder !== '0) begin
            n_fail++;
            $display("FAIL running_outputs: got busy=%b rdy=%b q=%h r=%h, need 1 0 0 0",
                     busy, rdy, quotient, remainder);
        end
        wait_rdy(cyc);
        n_checks++;
        if (cyc !== 32) begin
            n_fail++; $display("FAIL latency_100_7: got %0d edges, need 32", cyc);
        end
        n_checks++;
        if (quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL result_100_7: got q=%0d r=%0d dz=%b busy=%b, need 14 2 0 0",
                     quotient, remainder, div_by_zero, busy);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (rdy !== 1'b1 || quotient !== 32'd14) begin
            n_fail++; $display("FAIL result_hold: got rdy=%b q=%0d, need 1 14", rdy, quotient);
        end
    endtask

    task automatic test_extremes;
        int cyc;
        pulse_start(32'hFFFF_FFFF, 32'd1);
        wait_rdy(cyc);
        n_checks++;
        if (cyc !== 32 || quotient !== 32'hFFFF_FFFF || remainder !== 32'd0) begin
            n_fail++;
            $display("FAIL max_div_1: got cyc=%0d q=%h r=%h, need 32 ffffffff 0", cyc, quotient, remainder);
        end
        pulse_start(32'd3, 32'd10);
        wait_rdy(cyc);
        n_checks++;
        if (quotient !== 32'd0 || remainder !== 32'd3) begin
            n_fail++; $display("FAIL small_div_large: got q=%0d r=%0d, need 0 3", quotient, remainder);
        end
    endtask

    task automatic test_div_zero;
        pulse_start(32'd5, 32'd0);
        n_checks++;
        if (rdy !== 1'b1 || busy !== 1'b0 || quotient !== 32'hFFFF_FFFF ||
            remainder !== 32'd5 || div_by_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL div_zero: got rdy=%b busy=%b q=%h r=%0d dz=%b, need 1 0 ffffffff 5 1",
                     rdy, busy, quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_start_ignored;
        int cyc;
        pulse_start(32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        start = 1'b1; dividend_in = 32'd8; divisor_in = 32'd2;
        @(negedge clk);
        start = 1'b0;
        wait_rdy(cyc);
        cyc = cyc + 10;
        n_checks++;
        if (cyc !== 32 || quotient !== 32'd333 || remainder !== 32'd1) begin
            n_fail++;
            $display("FAIL start_in_run: got cyc=%0d q=%0d r=%0d, need 32 333 1", cyc, quotient, remainder);
        end
    endtask

    task automatic test_reset_abort;
        int cyc;
        bit seen;
        pulse_start(32'd1000, 32'd3);
        repeat (16) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, rdy, div_by_zero, quotient, remainder} !== '0) begin
            n_fail++;
            $display("FAIL reset_in_run: got busy=%b rdy=%b dz=%b q=%h r=%h, need all 0",
                     busy, rdy, div_by_zero, quotient, remainder);
        end
        @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (rdy || busy) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL abort_no_result: got activity=1, need 0");
        end
        pulse_start(32'd81, 32'd9);
        wait_rdy(cyc);
        n_checks++;
        if (cyc !== 32 || quotient !== 32'd9 || remainder !== 32'd0) begin
            n_fail++;
            $display("FAIL after_reset_81_9: got cyc=%0d q=%0d r=%0d, need 32 9 0", cyc, quotient, remainder);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        int low;
        pulse_start(32'd42, 32'd5);
        wait_rdy(cyc);
        n_checks++;
        if (quotient !== 32'd8 || remainder !== 32'd2) begin
            n_fail++; $display("FAIL b2b_first: got q=%0d r=%0d, need 8 2", quotient, remainder);
        end
        start = 1'b1; dividend_in = 32'd7; divisor_in = 32'd7;
        @(negedge clk);
        start = 1'b0;
        low = 0;
        while (!rdy && low < 100) begin
            low++;
            @(negedge clk);
        end
        n_checks++;
        if (low !== 32 || quotient !== 32'd1 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second: got low=%0d q=%0d r=%0d dz=%b, need 32 1 0 0",
                     low, quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_random;
        int cyc;
        logic [W-1:0] a, b;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case (i % 5)
                0: b = $urandom_range(1, 15);
                1: b = $urandom | 32'h8000_0000;
                2: b = (i % 10 == 2) ? 32'd0 : $urandom_range(1, 65535);
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            pulse_start(a, b);
            wait_rdy(cyc);
            n_checks++;
            if (cyc !== ((b == 0) ? 0 : 32) || quotient !== model_q(a, b) ||
                remainder !== model_r(a, b) || div_by_zero !== (b == 0)) begin
                n_fail++;
                $display("FAIL random_%0d: %h/%h got cyc=%0d q=%h r=%h dz=%b, need q=%h r=%h",
                         i, a, b, cyc, quotient, remainder, div_by_zero, model_q(a, b), model_r(a, b));
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_basic();
        test_extremes();
        test_div_zero();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/unsigned_divider.md
UNSIGNED_DIVIDER -- requirements
Module: unsigned_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin a division, sampled on the rising clk edge.
REQ-005 SHALL have port dividend_in  input  WIDTH  unsigned dividend, sampled with an accepted start.
REQ-006 SHALL have port divisor_in  input  WIDTH  unsigned divisor, sampled with an accepted start.
REQ-007 SHALL have port busy  output  1  high while a division is in progress.
REQ-008 SHALL have port rdy  output  1  high while quotient/remainder are valid.
REQ-009 SHALL have port quotient  output  WIDTH  result quotient.
REQ-010 SHALL have port remainder  output  WIDTH  result remainder.
REQ-011 SHALL have port div_by_zero  output  1  high with rdy when the accepted divisor was 0.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; all state, counter and the register update on the rising clk edge.
REQ-013 Start SHALL be accepted only in IDLE or DONE; a start in RUN SHALL be ignored, with no effect on the operation in progress.
REQ-014 On accept with divisor_in != 0: load the 2*WIDTH working register {WIDTH'b0, dividend_in}, latch the divisor, clear the iteration counter, go to RUN, and drop rdy and div_by_zero.
REQ-015 On accept with divisor_in == 0: go directly to DONE on that edge, with quotient = all ones, remainder = dividend_in, div_by_zero = 1 and rdy = 1.
REQ-016 Each RUN cycle SHALL perform one restoring step: shift the working register left by 1, then compute upper half minus divisor as a WIDTH+1-bit result.
REQ-017 In that step, if there is no borrow, the upper half SHALL take the difference and bit 0 SHALL be set to 1; otherwise the shifted upper half SHALL be kept and bit 0 SHALL be 0.
REQ-018 RUN SHALL last exactly WIDTH cycles, counted by a counter of width clog2(WIDTH)+1; after the WIDTH-th step the FSM SHALL go to DONE.
REQ-019 Latency: start accepted at edge N SHALL give rdy = 1 after edge N+WIDTH (33 edges total for WIDTH = 32).
REQ-020 In DONE: quotient = working[WIDTH-1:0], remainder = working[2*WIDTH-1:WIDTH], rdy = 1, busy = 0; results SHALL hold until the next accepted start or reset.
REQ-021 busy SHALL be 1 exactly in RUN.
REQ-022 quotient and remainder SHALL be 0 whenever rdy = 0.
REQ-023 A start arriving in DONE on the same edge the results would be read SHALL begin the new operation; the old results are lost on that edge.
REQ-024 Arithmetic SHALL be unsigned, with no overflow possible: quotient <= dividend and remainder < divisor.

Reset
REQ-025 rst high SHALL immediately force IDLE, a zero working register, zero latched divisor and zero counter, with busy = 0, rdy = 0, div_by_zero = 0, quotient = 0 and remainder = 0.
REQ-026 A reset asserted during RUN SHALL abort the operation; no result SHALL appear, and the first start after rst deasserts SHALL be accepted normally.

Structure
REQ-027 Shared package div_pkg SHALL hold the FSM state type (IDLE/RUN/DONE) and the default WIDTH constant.
REQ-028 The datapath (working register, divisor register, WIDTH+1-bit subtractor) SHALL be one sub-module, div_datapath.
REQ-029 The FSM and counter SHALL live in unsigned_divider, driving div_datapath through load and step controls.

Verification
REQ-030 100 / 7 -> rdy after 32 RUN cycles, quotient = 14, remainder = 2, div_by_zero = 0.
REQ-031 32'hFFFFFFFF / 1 -> quotient = 32'hFFFFFFFF, remainder = 0; then 3 / 10 -> quotient = 0, remainder = 3.
REQ-032 5 / 0 -> rdy one edge after start, quotient = 32'hFFFFFFFF, remainder = 5, div_by_zero = 1.
REQ-033 Start 1000 / 3, then pulse start with 8 / 2 at RUN cycle 10 -> second request ignored, result quotient = 333, remainder = 1.
REQ-034 rst asserted at RUN cycle 16 -> all outputs 0 immediately; a following 81 / 9 gives quotient = 9, remainder = 0.
REQ-035 Back-to-back start in DONE (42 / 5 then 7 / 7) -> rdy drops for exactly 32 cycles, final quotient = 1, remainder = 0.
